// File: rtl/const_tie_array.sv
// Programmable tie-off generator: constant one/zero lines plus NCH tie lines reloaded
// through a serial shadow register and an atomic commit. Optional lock feature: CONST_LOCK_EN.
module const_tie_array #(
  parameter int             NCH           = 8,
  parameter logic [NCH-1:0] RESET_VAL     = 'h0F,
  parameter int             SETTLE_CYCLES = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           shift_en,
  input  logic           shift_din,
  input  logic           apply,
`ifdef CONST_LOCK_EN
  input  logic           lock,
  output logic           locked,
`endif
  output logic [NCH-1:0] one,
  output logic [NCH-1:0] zero,
  output logic [NCH-1:0] tie,
  output logic           shift_dout,
  output logic           ready,
  output logic           err
);

  localparam int BW = $clog2(NCH + 2);
  localparam logic [BW-1:0] BC_FULL = BW'(NCH);
  localparam logic [BW-1:0] BC_OVR  = BW'(NCH + 1);
  localparam logic [7:0]    CNT_END = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_SETTLE, S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NCH-1:0]  shadow_q, shadow_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [NCH-1:0]  tie_q, tie_d;
  logic            err_q, err_d;
`ifdef CONST_LOCK_EN
  logic            locked_q, locked_d;
  logic            lock_pend_q, lock_pend_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    bitcnt_d = bitcnt_q;
    tie_d    = tie_q;
    err_d    = 1'b0;
`ifdef CONST_LOCK_EN
    locked_d    = locked_q;
    lock_pend_d = lock_pend_q;
`endif
    case (state_q)
      S_SETTLE: begin
        if (cnt_q == CNT_END) state_d = S_IDLE;
        else                  cnt_d   = cnt_q + 8'd1;
      end
      S_IDLE: begin
`ifdef CONST_LOCK_EN
        // Once locked the block parks here for good; a deferred lock lands on the first idle cycle.
        if (locked_q) begin
        end else if (lock || lock_pend_q) begin
          locked_d    = 1'b1;
          lock_pend_d = 1'b0;
        end else
`endif
        if (apply) begin
          err_d = 1'b1;
        end else if (shift_en) begin
          shadow_d = {shadow_q[NCH-2:0], shift_din};
          bitcnt_d = BW'(1);
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
`ifdef CONST_LOCK_EN
        lock_pend_d = lock_pend_q | lock;
`endif
        if (apply) begin
          if (!shift_en && bitcnt_q == BC_FULL) begin
            state_d = S_COMMIT;
          end else begin
            err_d    = 1'b1;
            shadow_d = tie_q;
            bitcnt_d = '0;
            state_d  = S_IDLE;
          end
        end else if (shift_en) begin
          shadow_d = {shadow_q[NCH-2:0], shift_din};
          if (bitcnt_q != BC_OVR) bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      S_COMMIT: begin
`ifdef CONST_LOCK_EN
        lock_pend_d = lock_pend_q | lock;
`endif
        tie_d    = shadow_q;
        bitcnt_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_SETTLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_SETTLE;
      cnt_q    <= '0;
      shadow_q <= RESET_VAL;
      bitcnt_q <= '0;
      tie_q    <= RESET_VAL;
      err_q    <= 1'b0;
`ifdef CONST_LOCK_EN
      locked_q    <= 1'b0;
      lock_pend_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      bitcnt_q <= bitcnt_d;
      tie_q    <= tie_d;
      err_q    <= err_d;
`ifdef CONST_LOCK_EN
      locked_q    <= locked_d;
      lock_pend_q <= lock_pend_d;
`endif
    end
  end

  assign one        = '1;
  assign zero       = '0;
  assign tie        = tie_q;
  assign err        = err_q;
  assign shift_dout = shadow_q[NCH-1];
`ifdef CONST_LOCK_EN
  assign locked = locked_q;
  assign ready  = (state_q == S_IDLE || state_q == S_SHIFT) && !locked_q;
`else
  assign ready  = (state_q == S_IDLE || state_q == S_SHIFT);
`endif

endmodule

// File: tb/tb_const_tie_array.sv
// Self-checking bench for const_tie_array (NCH=8, RESET_VAL=8'h0F, SETTLE_CYCLES=16).
module tb_const_tie_array;

  localparam logic [7:0] RV = 8'h0F;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       shift_en = 1'b0;
  logic       shift_din = 1'b0;
  logic       apply = 1'b0;
  logic [7:0] one, zero, tie;
  logic       shift_dout, ready, err;
`ifdef CONST_LOCK_EN
  logic       lock = 1'b0;
  logic       locked;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: shadow as a FIFO of bits (front = MSB), committed pattern, shift count.
  bit         mq[$];
  logic [7:0] m_tie;
  int         nshift;

  const_tie_array #(.NCH(8), .RESET_VAL(8'h0F), .SETTLE_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .shift_en(shift_en), .shift_din(shift_din), .apply(apply),
`ifdef CONST_LOCK_EN
    .lock(lock), .locked(locked),
`endif
    .one(one), .zero(zero), .tie(tie), .shift_dout(shift_dout), .ready(ready), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reload();
    mq.delete();
    for (int i = 7; i >= 0; i--) mq.push_back(m_tie[i]);
    nshift = 0;
  endtask

  // Release reset mid-cycle and count the settle window; optionally drive noise on the inputs.
  task automatic test_settle(input bit noisy);
    #1;
    reset = 1'b0;
    m_tie = RV;
    model_reload();
    for (int i = 1; i <= 16; i++) begin
      if (noisy) begin
        shift_en = 1'($urandom); apply = 1'($urandom); shift_din = 1'($urandom);
      end
      tick();
      if (i < 16) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL settle_ready c%0d: got %b expected 0", i, ready); end
      end
      checks++;
      if (tie !== RV || err !== 1'b0) begin
        errors++; $display("FAIL settle_hold c%0d: tie=%h err=%b expected tie=%h err=0", i, tie, err, RV);
      end
    end
    shift_en = 1'b0; apply = 1'b0; shift_din = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL settle_done: ready=%b expected 1", ready); end
  endtask

  task automatic shift_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      shift_en  = 1'b1;
      shift_din = val[i];
      checks++;
      if (shift_dout !== mq[0]) begin
        errors++; $display("FAIL shift_dout bit%0d: got %b expected %b", nshift, shift_dout, mq[0]);
      end
      void'(mq.pop_front());
      mq.push_back(val[i]);
      nshift++;
      tick();
    end
    shift_en = 1'b0;
  endtask

  task automatic do_apply(input bit with_shift);
    logic [7:0] new_tie;
    bit ok;
    ok = (nshift == 8) && !with_shift;
    for (int i = 0; i < 8; i++) new_tie[7-i] = mq[i];
    apply = 1'b1; shift_en = with_shift; shift_din = 1'($urandom);
    tick();
    apply = 1'b0; shift_en = 1'b0;
    if (ok) begin
      checks++;
      if (err !== 1'b0 || ready !== 1'b0 || tie !== m_tie) begin
        errors++; $display("FAIL commit_cycle: err=%b ready=%b tie=%h expected 0 0 %h", err, ready, tie, m_tie);
      end
      tick();
      m_tie = new_tie;
      checks++;
      if (tie !== m_tie || ready !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL commit_done: tie=%h ready=%b err=%b expected %h 1 0", tie, ready, err, m_tie);
      end
      model_reload();
    end else begin
      checks++;
      if (err !== 1'b1 || tie !== m_tie || ready !== 1'b1) begin
        errors++; $display("FAIL reject: err=%b tie=%h ready=%b expected 1 %h 1", err, tie, ready, m_tie);
      end
      model_reload();
      tick();
      checks++;
      if (err !== 1'b0 || tie !== m_tie) begin
        errors++; $display("FAIL reject_end: err=%b tie=%h expected 0 %h", err, tie, m_tie);
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    tick(); tick();
    checks++;
    if (tie !== RV || one !== 8'hFF || zero !== 8'h00) begin
      errors++; $display("FAIL reset_lines: tie=%h one=%h zero=%h expected %h ff 00", tie, one, zero, RV);
    end
    checks++;
    if (ready !== 1'b0 || err !== 1'b0 || shift_dout !== RV[7]) begin
      errors++; $display("FAIL reset_ctrl: ready=%b err=%b dout=%b expected 0 0 %b", ready, err, shift_dout, RV[7]);
    end
`ifdef CONST_LOCK_EN
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
`endif
    test_settle(1'b0);
    checks++;
    if (one !== 8'hFF || zero !== 8'h00) begin
      errors++; $display("FAIL const_lines: one=%h zero=%h expected ff 00", one, zero);
    end
  endtask

  task automatic test_reject();
    shift_bits(32'h5B, 7); do_apply(1'b0);
    shift_bits(32'h1A5, 9); do_apply(1'b0);
    shift_bits(32'hC3, 8); do_apply(1'b1);
    do_apply(1'b0);
    checks++;
    if (tie !== RV) begin errors++; $display("FAIL reject_tie: got %h expected %h", tie, RV); end
  endtask

  task automatic test_commit();
    shift_bits(32'hA5, 8);
    do_apply(1'b0);
    checks++;
    if (tie !== 8'hA5) begin errors++; $display("FAIL commit_a5: got %h expected a5", tie); end
  endtask

  task automatic test_back_to_back();
    shift_bits(32'h3C, 8); do_apply(1'b0);
    shift_bits(32'hE1, 8); do_apply(1'b0);
    checks++;
    if (tie !== 8'hE1) begin errors++; $display("FAIL b2b: got %h expected e1", tie); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int n;
      bit sim;
      n   = ($urandom_range(0, 1) == 1) ? 8 : int'($urandom_range(0, 10));
      sim = ($urandom_range(0, 4) == 0);
      shift_bits(32'($urandom), n);
      do_apply(sim);
    end
  endtask

  task automatic test_mid_reset();
    shift_bits(32'hA5, 8); do_apply(1'b0);
    shift_bits(32'h3, 4);
    reset = 1'b1;
    #1;
    checks++;
    if (tie !== RV || ready !== 1'b0 || shift_dout !== RV[7]) begin
      errors++; $display("FAIL midshift_reset: tie=%h ready=%b dout=%b expected %h 0 %b", tie, ready, shift_dout, RV, RV[7]);
    end
    test_settle(1'b1);
    shift_bits(32'h3C, 8); do_apply(1'b0);
    shift_bits(32'h5A, 8);
    apply = 1'b1; tick(); apply = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (tie !== RV || ready !== 1'b0) begin
      errors++; $display("FAIL midcommit_reset: tie=%h ready=%b expected %h 0", tie, ready, RV);
    end
    test_settle(1'b0);
  endtask

`ifdef CONST_LOCK_EN
  task automatic test_lock();
    shift_bits(32'h81, 8); do_apply(1'b0);
    lock = 1'b1; tick(); lock = 1'b0;
    checks++;
    if (locked !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL lock_set: locked=%b ready=%b expected 1 0", locked, ready);
    end
    for (int i = 0; i < 8; i++) begin
      shift_en = 1'b1; shift_din = 1'b1; tick();
    end
    shift_en = 1'b0;
    apply = 1'b1; tick(); apply = 1'b0;
    checks++;
    if (err !== 1'b0 || tie !== 8'h81) begin
      errors++; $display("FAIL lock_frozen: err=%b tie=%h expected 0 81", err, tie);
    end
    tick();
    checks++;
    if (err !== 1'b0 || tie !== 8'h81 || ready !== 1'b0) begin
      errors++; $display("FAIL lock_frozen2: err=%b tie=%h ready=%b expected 0 81 0", err, tie, ready);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_reset: locked=%b expected 0", locked); end
    test_settle(1'b0);
  endtask

  task automatic test_lock_deferred();
    shift_bits(32'h8, 4);
    lock = 1'b1;
    shift_bits(32'h1, 4);
    lock = 1'b0;
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_defer_early: locked=%b expected 0", locked); end
    do_apply(1'b0);
    tick();
    checks++;
    if (locked !== 1'b1 || ready !== 1'b0 || tie !== 8'h81) begin
      errors++; $display("FAIL lock_defer: locked=%b ready=%b tie=%h expected 1 0 81", locked, ready, tie);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reject();
    test_commit();
    test_back_to_back();
    test_random();
    test_mid_reset();
`ifdef CONST_LOCK_EN
    test_lock();
    test_lock_deferred();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
